// File: rtl/sram_xbar_n.sv
`default_nettype none
// ============================================================================
// Module   : sram_xbar_n
// Purpose  : Single-master, N-slave address-decoded crossbar for the SRAM-style
//            data bus. Fully pipelined, one access per cycle, no stalls.
//            Decode misses return ERR_DATA, pulse master_err when the
//            response is due, and are logged in sticky error registers.
// Ports    : clk, rst (async, active-low)
//            master_* : request in (addr/din/ena/wea), response out (douta/err)
//            slave_*  : per-slave packed request out, per-slave read data in
//            err_*    : sticky first-miss log (valid/addr) + saturating count,
//                       cleared by err_clear
// Revision : 1.0  initial release
// ============================================================================
module sram_xbar_n #(
    parameter int unsigned                     LEN_ADDR   = 64,
    parameter int unsigned                     LEN_DATA   = 64,
    parameter int unsigned                     NUM_SLAVES = 4,
    parameter logic [NUM_SLAVES*LEN_ADDR-1:0]  SLAVE_BASE = '0,
    parameter logic [NUM_SLAVES*LEN_ADDR-1:0]  SLAVE_MASK = '0,
    parameter int unsigned                     RD_LATENCY = 1,
    parameter logic [63:0]                     ERR_DATA   = 64'hDEAD_BEEF_DEAD_BEEF
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [LEN_ADDR-1:0]                master_addra,
    input  logic [LEN_DATA-1:0]                master_dina,
    input  logic                               master_ena,
    input  logic [LEN_DATA/8-1:0]              master_wea,
    output logic [LEN_DATA-1:0]                master_douta,
    output logic                               master_err,
    output logic [NUM_SLAVES*LEN_ADDR-1:0]     slave_addra,
    output logic [NUM_SLAVES*LEN_DATA-1:0]     slave_dina,
    input  logic [NUM_SLAVES*LEN_DATA-1:0]     slave_douta,
    output logic [NUM_SLAVES-1:0]              slave_ena,
    output logic [NUM_SLAVES*LEN_DATA/8-1:0]   slave_wea,
    input  logic                               err_clear,
    output logic                               err_valid,
    output logic [LEN_ADDR-1:0]                err_addr,
    output logic [15:0]                        err_count
);

    localparam int unsigned       c_be_w     = LEN_DATA / 8;
    localparam logic [LEN_DATA-1:0] c_err_data = ERR_DATA[LEN_DATA-1:0];

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [NUM_SLAVES-1:0] w_hit;
    logic [NUM_SLAVES-1:0] w_sel;
    logic [3:0]            w_sel_idx;
    logic                  w_any_hit;
    logic                  w_miss;

    genvar gi;
    for (gi = 0; gi < int'(NUM_SLAVES); gi++) begin : g_hit
        assign w_hit[gi] = (master_addra & SLAVE_MASK[gi*LEN_ADDR +: LEN_ADDR])
                           == SLAVE_BASE[gi*LEN_ADDR +: LEN_ADDR];
    end

    // Scanning from the top index down lets the lowest hitting index
    // overwrite the others, so overlapping windows resolve to the lowest.
    always_comb begin
        w_sel_idx = '0;
        for (int i = int'(NUM_SLAVES) - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_sel_idx = 4'(i);
            end
        end
    end

    assign w_any_hit = |w_hit;
    assign w_miss    = master_ena & ~w_any_hit;

    always_comb begin
        w_sel = '0;
        for (int i = 0; i < int'(NUM_SLAVES); i++) begin
            w_sel[i] = w_any_hit && (w_sel_idx == 4'(i));
        end
    end

    // ------------------------------------------------------------------
    // Request fan-out
    // ------------------------------------------------------------------
    for (gi = 0; gi < int'(NUM_SLAVES); gi++) begin : g_fanout
        assign slave_addra[gi*LEN_ADDR +: LEN_ADDR] = master_addra;
        assign slave_dina[gi*LEN_DATA +: LEN_DATA]  = master_dina;
        assign slave_ena[gi]                        = master_ena & w_sel[gi];
        assign slave_wea[gi*c_be_w +: c_be_w]       = w_sel[gi] ? master_wea : '0;
    end

    // ------------------------------------------------------------------
    // Response tracking pipeline
    //
    // The hold registers are the final stage: they must point at the
    // winning slave in exactly the cycle its douta becomes valid, i.e. they
    // load on the RD_LATENCY-th edge after the request. The stages feeding
    // them are therefore the live request (stage 0) followed by
    // RD_LATENCY-1 registered stages.
    // ------------------------------------------------------------------
    logic       w_last_valid;
    logic [3:0] w_last_idx;
    logic       w_last_miss;

    if (RD_LATENCY <= 1) begin : g_lat1
        assign w_last_valid = master_ena;
        assign w_last_idx   = w_sel_idx;
        assign w_last_miss  = w_miss;
    end else begin : g_latn
        logic [RD_LATENCY-2:0] pipe_valid_q;
        logic [RD_LATENCY-2:0] pipe_valid_d;
        logic [RD_LATENCY-2:0] pipe_miss_q;
        logic [RD_LATENCY-2:0] pipe_miss_d;
        logic [3:0]            pipe_idx_q [RD_LATENCY-1];
        logic [3:0]            pipe_idx_d [RD_LATENCY-1];

        always_comb begin
            pipe_valid_d  = '0;
            pipe_miss_d   = '0;
            for (int k = 0; k < int'(RD_LATENCY) - 1; k++) begin
                pipe_idx_d[k] = '0;
            end
            pipe_valid_d[0] = master_ena;
            pipe_miss_d[0]  = w_miss;
            pipe_idx_d[0]   = w_sel_idx;
            for (int k = 1; k < int'(RD_LATENCY) - 1; k++) begin
                pipe_valid_d[k] = pipe_valid_q[k-1];
                pipe_miss_d[k]  = pipe_miss_q[k-1];
                pipe_idx_d[k]   = pipe_idx_q[k-1];
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                pipe_valid_q <= '0;
                pipe_miss_q  <= '0;
                for (int k = 0; k < int'(RD_LATENCY) - 1; k++) begin
                    pipe_idx_q[k] <= '0;
                end
            end else begin
                pipe_valid_q <= pipe_valid_d;
                pipe_miss_q  <= pipe_miss_d;
                for (int k = 0; k < int'(RD_LATENCY) - 1; k++) begin
                    pipe_idx_q[k] <= pipe_idx_d[k];
                end
            end
        end

        assign w_last_valid = pipe_valid_q[RD_LATENCY-2];
        assign w_last_idx   = pipe_idx_q[RD_LATENCY-2];
        assign w_last_miss  = pipe_miss_q[RD_LATENCY-2];
    end

    // ------------------------------------------------------------------
    // Hold registers, error pulse and sticky error log
    // ------------------------------------------------------------------
    logic [3:0]          hold_idx_q,   hold_idx_d;
    logic                hold_miss_q,  hold_miss_d;
    logic                master_err_q, master_err_d;
    logic                err_valid_q,  err_valid_d;
    logic [LEN_ADDR-1:0] err_addr_q,   err_addr_d;
    logic [15:0]         err_count_q,  err_count_d;

    always_comb begin
        // Hold only moves on a real response so douta keeps SRAM hold
        // behaviour between accesses.
        hold_idx_d   = hold_idx_q;
        hold_miss_d  = hold_miss_q;
        if (w_last_valid) begin
            hold_idx_d  = w_last_idx;
            hold_miss_d = w_last_miss;
        end
        master_err_d = w_last_valid & w_last_miss;
    end

    always_comb begin
        err_valid_d = err_valid_q;
        err_addr_d  = err_addr_q;
        err_count_d = err_count_q;
        if (w_miss) begin
            // A miss coinciding with a clear restarts the log with itself.
            if (err_clear || !err_valid_q) begin
                err_valid_d = 1'b1;
                err_addr_d  = master_addra;
            end
            if (err_clear) begin
                err_count_d = 16'd1;
            end else if (err_count_q != 16'hFFFF) begin
                err_count_d = err_count_q + 16'd1;
            end
        end else if (err_clear) begin
            err_valid_d = 1'b0;
            err_addr_d  = '0;
            err_count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_idx_q   <= '0;
            hold_miss_q  <= 1'b0;
            master_err_q <= 1'b0;
            err_valid_q  <= 1'b0;
            err_addr_q   <= '0;
            err_count_q  <= '0;
        end else begin
            hold_idx_q   <= hold_idx_d;
            hold_miss_q  <= hold_miss_d;
            master_err_q <= master_err_d;
            err_valid_q  <= err_valid_d;
            err_addr_q   <= err_addr_d;
            err_count_q  <= err_count_d;
        end
    end

    // ------------------------------------------------------------------
    // Return mux
    // ------------------------------------------------------------------
    always_comb begin
        master_douta = slave_douta[0 +: LEN_DATA];
        for (int i = 1; i < int'(NUM_SLAVES); i++) begin
            if (hold_idx_q == 4'(i)) begin
                master_douta = slave_douta[i*LEN_DATA +: LEN_DATA];
            end
        end
        if (hold_miss_q) begin
            master_douta = c_err_data;
        end
    end

    assign master_err = master_err_q;
    assign err_valid  = err_valid_q;
    assign err_addr   = err_addr_q;
    assign err_count  = err_count_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_xbar_n.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_sram_xbar_n
// Purpose  : Self-checking bench for sram_xbar_n. Three instances share the
//            same stimulus and windows, differing only in RD_LATENCY (1,2,3).
// Revision : 1.0  initial release
// ============================================================================
module tb_sram_xbar_n;

    localparam int NS = 4;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int BW = 8;
    localparam int NI = 3;

    // slave windows: s1 and s2 overlap exactly
    localparam logic [63:0] B0 = 64'h0,           M0 = ~64'hFFFF;
    localparam logic [63:0] B1 = 64'h6000_0000,   M1 = ~64'h7;
    localparam logic [63:0] B2 = 64'h6000_0000,   M2 = ~64'h7;
    localparam logic [63:0] B3 = 64'h4000_0000,   M3 = ~64'hFF;
    localparam logic [NS*AW-1:0] P_BASE = {B3, B2, B1, B0};
    localparam logic [NS*AW-1:0] P_MASK = {M3, M2, M1, M0};
    localparam logic [63:0] ERRV = 64'hDEAD_BEEF_DEAD_BEEF;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [AW-1:0]     m_addr;
    logic [DW-1:0]     m_din;
    logic              m_ena;
    logic [BW-1:0]     m_wea;
    logic              err_clear;
    logic [NS*DW-1:0]  s_dout;

    logic [DW-1:0]     m_dout  [NI];
    logic              m_err   [NI];
    logic [NS*AW-1:0]  s_addr  [NI];
    logic [NS*DW-1:0]  s_din   [NI];
    logic [NS-1:0]     s_ena   [NI];
    logic [NS*BW-1:0]  s_wea   [NI];
    logic              e_valid [NI];
    logic [AW-1:0]     e_addr  [NI];
    logic [15:0]       e_cnt   [NI];

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    genvar g;
    for (g = 0; g < NI; g++) begin : g_dut
        sram_xbar_n #(
            .LEN_ADDR   (AW),
            .LEN_DATA   (DW),
            .NUM_SLAVES (NS),
            .SLAVE_BASE (P_BASE),
            .SLAVE_MASK (P_MASK),
            .RD_LATENCY (g + 1),
            .ERR_DATA   (ERRV)
        ) u_dut (
            .clk          (clk),
            .rst          (rst),
            .master_addra (m_addr),
            .master_dina  (m_din),
            .master_ena   (m_ena),
            .master_wea   (m_wea),
            .master_douta (m_dout[g]),
            .master_err   (m_err[g]),
            .slave_addra  (s_addr[g]),
            .slave_dina   (s_din[g]),
            .slave_douta  (s_dout),
            .slave_ena    (s_ena[g]),
            .slave_wea    (s_wea[g]),
            .err_clear    (err_clear),
            .err_valid    (e_valid[g]),
            .err_addr     (e_addr[g]),
            .err_count    (e_cnt[g])
        );
    end

    // Slave data changes every cycle and names its slave, so both the
    // selected slave and the response cycle are visible in master_douta.
    function automatic logic [63:0] pat(input int i, input int c);
        return {16'hA000 + 16'(i), 16'h0000, 32'(c)};
    endfunction

    always_comb begin
        s_dout = '0;
        for (int i = 0; i < NS; i++) s_dout[i*DW +: DW] = pat(i, cyc);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic ref_decode(input logic [63:0] a, output bit hit, output int idx);
        logic [NS*AW-1:0] pb;
        logic [NS*AW-1:0] pm;
        pb  = P_BASE;
        pm  = P_MASK;
        hit = 1'b0;
        idx = 0;
        for (int i = 0; i < NS; i++) begin
            if (!hit && ((a & pm[i*AW +: AW]) == pb[i*AW +: AW])) begin
                hit = 1'b1;
                idx = i;
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: responses scheduled by due cycle, sticky log
    // ------------------------------------------------------------------
    bit          due_v    [NI][8];
    int          due_idx  [NI][8];
    bit          due_miss [NI][8];
    int          h_idx    [NI];
    bit          h_miss   [NI];
    bit          mv;
    logic [63:0] ma;
    int          mc;

    initial begin : p_model
        bit hit;
        int idx;
        bit miss;
        int slot;
        mv = 0; ma = '0; mc = 0;
        for (int k = 0; k < NI; k++) begin
            h_idx[k] = 0; h_miss[k] = 0;
            for (int s = 0; s < 8; s++) due_v[k][s] = 0;
        end
        forever begin
            @(posedge clk);
            if (rst === 1'b1) begin
                ref_decode(m_addr, hit, idx);
                miss = m_ena && !hit;
                if (m_ena) begin
                    for (int k = 0; k < NI; k++) begin
                        slot = (cyc + k + 1) % 8;
                        due_v[k][slot]    = 1;
                        due_idx[k][slot]  = idx;
                        due_miss[k][slot] = miss;
                    end
                end
                if (miss) begin
                    if (err_clear || !mv) begin
                        mv = 1;
                        ma = m_addr;
                    end
                    mc = err_clear ? 1 : ((mc >= 65535) ? 65535 : mc + 1);
                end else if (err_clear) begin
                    mv = 0; ma = '0; mc = 0;
                end
            end
            cyc++;
        end
    end

    initial begin : p_cmp
        bit          hit;
        int          idx;
        int          s;
        bit          exp_e;
        logic [63:0] exp_d;
        logic [31:0] exp_w;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                mv = 0; ma = '0; mc = 0;
                for (int k = 0; k < NI; k++) begin
                    h_idx[k] = 0; h_miss[k] = 0;
                    for (int j = 0; j < 8; j++) due_v[k][j] = 0;
                end
            end
            ref_decode(m_addr, hit, idx);
            s = cyc % 8;
            for (int k = 0; k < NI; k++) begin
                exp_e = 0;
                if (due_v[k][s]) begin
                    h_idx[k]  = due_idx[k][s];
                    h_miss[k] = due_miss[k][s];
                    exp_e     = due_miss[k][s];
                    due_v[k][s] = 0;
                end
                exp_d = h_miss[k] ? ERRV : pat(h_idx[k], cyc);
                exp_w = hit ? (32'(m_wea) << (8 * idx)) : 32'h0;
                chk($sformatf("douta[%0d]", k), m_dout[k], exp_d);
                chk($sformatf("err[%0d]", k), 64'(m_err[k]), 64'(exp_e));
                chk($sformatf("err_valid[%0d]", k), 64'(e_valid[k]), 64'(mv));
                chk($sformatf("err_addr[%0d]", k), e_addr[k], ma);
                chk($sformatf("err_count[%0d]", k), 64'(e_cnt[k]), 64'(mc));
                chk($sformatf("slave_ena[%0d]", k), 64'(s_ena[k]),
                    (m_ena && hit) ? (64'h1 << idx) : 64'h0);
                chk($sformatf("slave_wea[%0d]", k), 64'(s_wea[k]), 64'(exp_w));
                for (int i = 0; i < NS; i++) begin
                    chk($sformatf("slave_addra[%0d][%0d]", k, i), s_addr[k][i*AW +: AW], m_addr);
                    chk($sformatf("slave_dina[%0d][%0d]", k, i), s_din[k][i*DW +: DW], m_din);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus with hand-computed literal expectations
    // ------------------------------------------------------------------
    task automatic drive(input logic [63:0] a, input logic e, input logic [7:0] w, input logic c);
        m_addr    = a;
        m_din     = ~a;
        m_ena     = e;
        m_wea     = w;
        err_clear = c;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin : p_watchdog
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : p_stim
        drive(64'h0, 0, 8'h00, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        tick();
        #1;
        chk("rst_err_valid", 64'(e_valid[0]), 64'h0);
        chk("rst_err_count", 64'(e_cnt[0]), 64'h0);
        chk("rst_douta_s0", 64'(m_dout[0][63:48]), 64'hA000);
        tick();

        // two-slave hit sequence
        drive(64'h10, 1, 8'h00, 0); #1;
        chk("hit_ena_s0", 64'(s_ena[0]), 64'b0001);
        tick();
        drive(64'h6000_0000, 1, 8'h00, 0); #1;
        chk("hit_ena_s1", 64'(s_ena[0]), 64'b0010);
        chk("hit_rd_s0_p1", 64'(m_dout[0][63:48]), 64'hA000);
        tick();
        drive(64'h0, 0, 8'h00, 0); #1;
        chk("hit_rd_s1_p2", 64'(m_dout[0][63:48]), 64'hA001);
        tick(); #1;
        chk("hit_hold_s1", 64'(m_dout[0][63:48]), 64'hA001);

        // decode miss
        drive(64'h7000_0000, 1, 8'h00, 0); #1;
        chk("miss_no_ena", 64'(s_ena[0]), 64'h0);
        tick();
        drive(64'h0, 0, 8'h00, 0); #1;
        chk("miss_err_pulse", 64'(m_err[0]), 64'h1);
        chk("miss_errdata", m_dout[0], ERRV);
        chk("miss_err_valid", 64'(e_valid[0]), 64'h1);
        chk("miss_err_addr", e_addr[0], 64'h7000_0000);
        chk("miss_err_count", 64'(e_cnt[0]), 64'h1);
        tick(); #1;
        chk("miss_err_once", 64'(m_err[0]), 64'h0);

        // overlapping windows, byte write
        drive(64'h6000_0004, 1, 8'h0F, 0); #1;
        chk("ovl_ena", 64'(s_ena[0]), 64'b0010);
        chk("ovl_wea1", 64'(s_wea[0][15:8]), 64'h0F);
        chk("ovl_wea2", 64'(s_wea[0][23:16]), 64'h00);
        tick();

        // latency 3: hit, miss, hit back to back
        drive(64'h10, 1, 8'h00, 0);          tick();
        drive(64'h7000_0008, 1, 8'h00, 0);   tick();
        drive(64'h4000_0010, 1, 8'h00, 0);   tick();
        drive(64'h0, 0, 8'h00, 0); #1;
        chk("l3_p3_s0", 64'(m_dout[2][63:48]), 64'hA000);
        chk("l3_p3_noerr", 64'(m_err[2]), 64'h0);
        tick(); #1;
        chk("l3_p4_err", 64'(m_err[2]), 64'h1);
        chk("l3_p4_data", m_dout[2], ERRV);
        tick(); #1;
        chk("l3_p5_s3", 64'(m_dout[2][63:48]), 64'hA003);
        chk("l3_p5_noerr", 64'(m_err[2]), 64'h0);
        tick(); #1;
        chk("l3_hold_s3", 64'(m_dout[2][63:48]), 64'hA003);

        // sticky log: first miss kept, count of two misses
        chk("sticky_addr_a", e_addr[0], 64'h7000_0000);
        chk("sticky_count_2", 64'(e_cnt[0]), 64'h2);

        // clear together with a miss: the miss wins
        drive(64'h7777_0000, 1, 8'h00, 1); tick();
        drive(64'h0, 0, 8'h00, 0); #1;
        chk("clrmiss_valid", 64'(e_valid[0]), 64'h1);
        chk("clrmiss_addr", e_addr[0], 64'h7777_0000);
        chk("clrmiss_count", 64'(e_cnt[0]), 64'h1);
        tick();

        // clear alone
        drive(64'h0, 0, 8'h00, 1); tick();
        drive(64'h0, 0, 8'h00, 0); #1;
        chk("clr_valid", 64'(e_valid[0]), 64'h0);
        chk("clr_addr", e_addr[0], 64'h0);
        chk("clr_count", 64'(e_cnt[0]), 64'h0);
        tick();

        // saturation
        for (int i = 0; i < 65540; i++) begin
            drive(64'h7000_0000 + (64'(i) << 4), 1, 8'h00, 0);
            tick();
        end
        drive(64'h0, 0, 8'h00, 0); #1;
        chk("sat_count", 64'(e_cnt[0]), 64'hFFFF);
        chk("sat_addr", e_addr[0], 64'h7000_0000);
        repeat (4) tick();

        // async reset with a miss in flight
        drive(64'h7000_0000, 1, 8'h00, 0); tick();
        drive(64'h0, 0, 8'h00, 0);
        #2 rst = 1'b0;
        #1;
        chk("arst_err", 64'(m_err[1]), 64'h0);
        chk("arst_valid", 64'(e_valid[1]), 64'h0);
        chk("arst_count", 64'(e_cnt[1]), 64'h0);
        chk("arst_douta_s0", 64'(m_dout[1][63:48]), 64'hA000);
        tick();
        tick();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(); #1;
            chk("arst_no_err_after", 64'(m_err[1]), 64'h0);
        end
        chk("arst_err_addr", e_addr[1], 64'h0);
        chk("arst_douta_after", 64'(m_dout[1][63:48]), 64'hA000);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
